// File: rtl/axi_lite_master_bridge.sv
// rtl/axi_lite_master_bridge.sv - single-outstanding AXI4-Lite master bridge with response timeout
module axi_lite_master_bridge #(
   parameter int         ADDR_W  = 32,
   parameter int         DATA_W  = 32,
   parameter logic [2:0] PROT    = 3'b000,
   parameter int         TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic [ADDR_W-1:0]   axi_araddr,
   output logic                axi_arvalid,
   output logic [2:0]          axi_arprot,
   input  logic                axi_arready,
   input  logic [DATA_W-1:0]   axi_rdata,
   input  logic [1:0]          axi_rresp,
   input  logic                axi_rvalid,
   output logic                axi_rready,
   output logic [ADDR_W-1:0]   axi_awaddr,
   output logic                axi_awvalid,
   output logic [2:0]          axi_awprot,
   input  logic                axi_awready,
   output logic [DATA_W-1:0]   axi_wdata,
   output logic [DATA_W/8-1:0] axi_wstrb,
   output logic                axi_wvalid,
   input  logic                axi_wready,
   input  logic [1:0]          axi_bresp,
   input  logic                axi_bvalid,
   output logic                axi_bready,
   output logic [2:0]          debug_state
);
   localparam int STRB_W  = DATA_W / 8;
   localparam int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR     = 3'd1,
      WAIT_B = 3'd2,
      RD_A   = 3'd3,
      WAIT_R = 3'd4,
      DRAIN  = 3'd5
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic [DATA_W-1:0]   wdata_n, resp_rdata_n;
   logic [STRB_W-1:0]   wstrb_n;
   logic                ar_valid_n, aw_valid_n, w_valid_n, b_ready_n, r_ready_n;
   logic                resp_valid_n, resp_err_n;
   logic                accept, busy, beat, timeout_hit;
   logic                ar_left, aw_left, w_left;
   logic                unused_resp;

   assign unused_resp = axi_bresp[0] ^ axi_rresp[0];
   assign req_ready   = (state == IDLE);
   assign debug_state = state;
   assign axi_arprot  = PROT;
   assign axi_awprot  = PROT;
   assign axi_araddr  = addr_q;
   assign axi_awaddr  = addr_q;

   assign accept  = req_valid && req_ready;
   assign busy    = state inside {WR, WAIT_B, RD_A, WAIT_R};
   assign beat    = (axi_bvalid && axi_bready) || (axi_rvalid && axi_rready);
   assign ar_left = axi_arvalid && !axi_arready;
   assign aw_left = axi_awvalid && !axi_awready;
   assign w_left  = axi_wvalid && !axi_wready;
   // A response beat in the final allowed cycle beats the timeout
   assign timeout_hit = (TIMEOUT != 0) && busy && (cnt == CNT_W'(TO_LAST)) && !beat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         axi_wdata   <= '0;
         axi_wstrb   <= '0;
         axi_arvalid <= 1'b0;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_bready  <= 1'b0;
         axi_rready  <= 1'b0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_rdata  <= '0;
      end else begin
         state       <= state_n;
         addr_q      <= addr_n;
         axi_wdata   <= wdata_n;
         axi_wstrb   <= wstrb_n;
         axi_arvalid <= ar_valid_n;
         axi_awvalid <= aw_valid_n;
         axi_wvalid  <= w_valid_n;
         axi_bready  <= b_ready_n;
         axi_rready  <= r_ready_n;
         resp_valid  <= resp_valid_n;
         resp_err    <= resp_err_n;
         resp_rdata  <= resp_rdata_n;
         if (accept)
            cnt <= '0;
         else if (busy)
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (accept) state_n = req_we ? WR : RD_A;
         WR:     if (timeout_hit) state_n = DRAIN;
                 else if (!aw_left && !w_left) state_n = WAIT_B;
         WAIT_B: if (beat) state_n = IDLE;
                 else if (timeout_hit) state_n = DRAIN;
         RD_A:   if (timeout_hit) state_n = DRAIN;
                 else if (axi_arready) state_n = WAIT_R;
         WAIT_R: if (beat) state_n = IDLE;
                 else if (timeout_hit) state_n = DRAIN;
         DRAIN:  if (beat) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      ar_valid_n   = ar_left;
      aw_valid_n   = aw_left;
      w_valid_n    = w_left;
      b_ready_n    = axi_bready;
      r_ready_n    = axi_rready;
      addr_n       = addr_q;
      wdata_n      = axi_wdata;
      wstrb_n      = axi_wstrb;
      resp_valid_n = 1'b0;
      resp_err_n   = 1'b0;
      resp_rdata_n = '0;
      case (state)
         IDLE: if (accept) begin
            addr_n     = req_addr;
            wdata_n    = req_wdata;
            wstrb_n    = req_wstrb;
            aw_valid_n = req_we;
            w_valid_n  = req_we;
            ar_valid_n = !req_we;
         end
         WR:     if (!timeout_hit && !aw_left && !w_left) b_ready_n = 1'b1;
         WAIT_B: if (beat) begin
            resp_valid_n = 1'b1;
            resp_err_n   = axi_bresp[1];
            b_ready_n    = 1'b0;
         end
         RD_A:   if (!timeout_hit && axi_arready) r_ready_n = 1'b1;
         WAIT_R: if (beat) begin
            resp_valid_n = 1'b1;
            resp_err_n   = axi_rresp[1];
            resp_rdata_n = axi_rdata;
            r_ready_n    = 1'b0;
         end
         DRAIN:  if (beat) begin
            b_ready_n = 1'b0;
            r_ready_n = 1'b0;
         end
         default: begin
            ar_valid_n = 1'b0;
            aw_valid_n = 1'b0;
            w_valid_n  = 1'b0;
            b_ready_n  = 1'b0;
            r_ready_n  = 1'b0;
         end
      endcase
      // Report the error now, but keep pending valids up and accept the late beat in DRAIN
      if (timeout_hit) begin
         resp_valid_n = 1'b1;
         resp_err_n   = 1'b1;
         resp_rdata_n = '0;
         if (state == WR || state == WAIT_B)
            b_ready_n = 1'b1;
         else
            r_ready_n = 1'b1;
      end
   end
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb/tb_axi_lite_master_bridge.sv - randomized bench for axi_lite_master_bridge with reactive slave model
module tb_axi_lite_master_bridge;
   localparam int         AW = 32;
   localparam int         DW = 64;
   localparam int         SW = DW / 8;
   localparam int         TO = 8;
   localparam logic [2:0] PR = 3'b010;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_wstrb;
   logic          resp_valid, resp_err;
   logic [DW-1:0] resp_rdata;
   logic [AW-1:0] axi_araddr, axi_awaddr;
   logic          axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
   logic [2:0]    axi_arprot, axi_awprot, debug_state;
   logic [DW-1:0] axi_rdata, axi_wdata;
   logic [SW-1:0] axi_wstrb;
   logic [1:0]    axi_rresp, axi_bresp;

   int n_checks = 0;
   int n_pass   = 0;

   axi_lite_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .PROT(PR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .debug_state(debug_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic slave_idle();
      axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
      axi_rvalid  = 1'b0; axi_bvalid  = 1'b0;
      axi_rdata   = '0;   axi_rresp   = 2'b00; axi_bresp = 2'b00;
   endtask

   // Starts at a negedge in IDLE; returns at the negedge where the bridge is back in IDLE
   task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] ws, input int da, input int dw, input int dr,
                          input logic [1:0] rc, input logic [DW-1:0] rd);
      int c = 1, a_wait = 0, w_wait = 0, r_wait = 0, a_high = 0, w_high = 0;
      int beat = -1, nresp = 0, got_cyc = -1, bad = 0, exp_cyc;
      bit a_done = 1'b0, w_done = !we, done = 1'b0;
      logic [DW-1:0] got_data = '0, exp_data;
      logic got_err = 1'b0, exp_err, av;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      check("req_ready_at_accept", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      while (!done && c < 80) begin
         slave_idle();
         av = we ? axi_awvalid : axi_arvalid;
         if (resp_valid) begin
            nresp++;
            if (nresp == 1) begin
               got_cyc = c; got_data = resp_rdata; got_err = resp_err;
            end
         end
         if (a_done && w_done && beat < 0) begin
            if (r_wait == dr) begin
               if (we) begin axi_bvalid = 1'b1; axi_bresp = rc; end
               else begin axi_rvalid = 1'b1; axi_rresp = rc; axi_rdata = rd; end
               if (we ? axi_bready : axi_rready) beat = c;
            end else r_wait++;
         end
         if (!a_done) begin
            if (!av) bad++;
            else begin
               a_high++;
               if ((we ? axi_awaddr : axi_araddr) !== addr) bad++;
               if ((we ? axi_awprot : axi_arprot) !== PR) bad++;
               if (a_wait == da) begin
                  if (we) axi_awready = 1'b1; else axi_arready = 1'b1;
                  a_done = 1'b1;
               end else a_wait++;
            end
         end else if (av) a_high++;
         if (we) begin
            if (!w_done) begin
               if (!axi_wvalid) bad++;
               else begin
                  w_high++;
                  if (axi_wdata !== wd || axi_wstrb !== ws) bad++;
                  if (w_wait == dw) begin axi_wready = 1'b1; w_done = 1'b1; end
                  else w_wait++;
               end
            end else if (axi_wvalid) w_high++;
         end
         if (beat >= 0 && c > beat && nresp > 0 && debug_state == 3'd0) done = 1'b1;
         else begin
            tick();
            c++;
         end
      end
      slave_idle();
      if (beat >= 0 && beat <= TO) begin
         exp_cyc = beat + 1; exp_err = rc[1]; exp_data = we ? '0 : rd;
      end else begin
         exp_cyc = TO + 1; exp_err = 1'b1; exp_data = '0;
      end
      check("txn_done_in_budget", 64'(done), 64'd1);
      check("resp_cycle", 64'(got_cyc), 64'(exp_cyc));
      check("resp_rdata", got_data, exp_data);
      check("resp_err", 64'(got_err), 64'(exp_err));
      check("resp_count", 64'(nresp), 64'd1);
      check("addr_valid_cycles", 64'(a_high), 64'(da + 1));
      if (we) check("wvalid_cycles", 64'(w_high), 64'(dw + 1));
      check("axi_rule_violations", 64'(bad), 64'd0);
      check("req_ready_after", 64'(req_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      slave_idle();
      repeat (2) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_rdata", resp_rdata, 64'd0);
      check("rst_valids", 64'({axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, axi_rready}), 64'd0);
      check("rst_addr_data", 64'(axi_araddr | axi_awaddr) | axi_wdata | 64'(axi_wstrb), 64'd0);
      check("rst_prot", 64'({axi_arprot, axi_awprot}), 64'({PR, PR}));
      check("rst_debug_state", 64'(debug_state), 64'd0);
      rst = 1'b0;

      run_txn(1'b0, 32'h0000_1004, '0, '0, 0, 0, 0, 2'b00, 64'hDEAD_BEEF);
      run_txn(1'b1, 32'h0000_2000, 64'h1234_5678, 8'h03, 3, 0, 0, 2'b00, '0);
      run_txn(1'b0, 32'h0000_3008, '0, '0, 1, 0, 2, 2'b10, 64'hCAFE_F00D_0BAD_1DEA);
      run_txn(1'b1, 32'h0000_300C, 64'hA5A5, 8'h01, 0, 2, 1, 2'b11, '0);
      run_txn(1'b0, 32'h0000_4000, '0, '0, 12, 0, 0, 2'b00, 64'h1111);
      run_txn(1'b0, 32'h0000_4010, '0, '0, 0, 0, 6, 2'b00, 64'h2222);
      run_txn(1'b0, 32'h0000_4020, '0, '0, 0, 0, 7, 2'b00, 64'h3333);
      run_txn(1'b1, 32'h0000_5000, 64'hFFEE_DDCC_BBAA_9988, 8'hF0, 10, 1, 0, 2'b00, '0);
      run_txn(1'b1, 32'h0000_6000, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 0, 0, 2'b00, '0);
      run_txn(1'b0, 32'h0000_6008, '0, '0, 0, 0, 0, 2'b01, 64'hFEDC_BA98_7654_3210);

      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
      tick();
      req_valid = 1'b0;
      check("rst_test_arvalid", 64'(axi_arvalid), 64'd1);
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
      check("rst_test_in_wait_r", 64'(debug_state), 64'd4);
      check("rst_test_rready", 64'(axi_rready), 64'd1);
      tick();
      rst = 1'b1;
      #1;
      check("midrst_valids", 64'({axi_arvalid, axi_awvalid, axi_wvalid, axi_bready, axi_rready}), 64'd0);
      check("midrst_resp_valid", 64'(resp_valid), 64'd0);
      check("midrst_debug_state", 64'(debug_state), 64'd0);
      check("midrst_req_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      run_txn(1'b0, 32'h0000_0044, '0, '0, 0, 0, 0, 2'b00, 64'h5555_6666);

      for (int i = 0; i < 40; i++) begin
         logic [1:0] rc;
         rc = 2'($urandom_range(0, 3));
         run_txn(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                 rc, {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
